// File: rtl/datapath_pkg.sv
// Shared constants and types for the single-bus datapath.
// Source offsets are relative to the first non-GPR bus source.
package datapath_pkg;

  localparam int NUM_GPR_DEF = 16;
  localparam int NUM_EXTRA   = 8;

  localparam int OFS_HI     = 0;
  localparam int OFS_LO     = 1;
  localparam int OFS_ZHI    = 2;
  localparam int OFS_ZLO    = 3;
  localparam int OFS_PC     = 4;
  localparam int OFS_MDR    = 5;
  localparam int OFS_INPORT = 6;
  localparam int OFS_C      = 7;

  localparam int SRC_HI     = NUM_GPR_DEF + OFS_HI;
  localparam int SRC_LO     = NUM_GPR_DEF + OFS_LO;
  localparam int SRC_ZHI    = NUM_GPR_DEF + OFS_ZHI;
  localparam int SRC_ZLO    = NUM_GPR_DEF + OFS_ZLO;
  localparam int SRC_PC     = NUM_GPR_DEF + OFS_PC;
  localparam int SRC_MDR    = NUM_GPR_DEF + OFS_MDR;
  localparam int SRC_INPORT = NUM_GPR_DEF + OFS_INPORT;
  localparam int SRC_C      = NUM_GPR_DEF + OFS_C;

  localparam int NUM_SRC = NUM_GPR_DEF + NUM_EXTRA;

  typedef enum logic {
    IDLE = 1'b0,
    READ = 1'b1
  } rd_state_e;

  function automatic int src_idx(input int n_gpr, input int ofs);
    return n_gpr + ofs;
  endfunction

  function automatic int num_src(input int n_gpr);
    return n_gpr + NUM_EXTRA;
  endfunction

endpackage

// File: rtl/bus_datapath_core_bus_encoder_mux.sv
// One-hot-to-index encoder feeding a WIDTH-bit source mux.
// Lowest set select wins; o_valid is low when nothing is selected.
module bus_encoder_mux #(
  parameter int N     = 24,
  parameter int WIDTH = 32,
  parameter int IW    = $clog2(N)
) (
  input  logic [N-1:0]       i_sel,
  input  logic [N*WIDTH-1:0] i_data,
  output logic               o_valid,
  output logic [WIDTH-1:0]   o_data
);

  logic [IW-1:0] w_idx;

  always_comb begin
    w_idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (i_sel[k]) w_idx = IW'(k);
    end
  end

  assign o_valid = |i_sel;
  assign o_data  = i_data[w_idx*WIDTH +: WIDTH];

endmodule

// File: rtl/bus_datapath_core.sv
// Single-bus datapath: GPRs, HI/LO, Z, Y, PC, MAR, MDR and memory read.
// Optional BUS_CONTENTION_CHECK_EN adds sticky bus_err / err_src.
module bus_datapath_core
  import datapath_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int NUM_GPR = 16,
  parameter int PC_STEP = 1
) (
  input  logic                       clock,
  input  logic                       clear,
  input  logic [NUM_GPR+NUM_EXTRA-1:0] out_en,
  input  logic [NUM_GPR-1:0]         gpr_in,
  input  logic                       hi_in,
  input  logic                       lo_in,
  input  logic                       y_in,
  input  logic                       pc_in,
  input  logic                       mar_in,
  input  logic                       z_in,
  input  logic                       pc_inc,
  input  logic                       mdr_in,
  input  logic                       mdr_rd,
  input  logic [WIDTH-1:0]           inport_data,
  input  logic [WIDTH-1:0]           c_sign_extended,
  input  logic [2*WIDTH-1:0]         alu_result,
  input  logic [WIDTH-1:0]           mem_rdata,
  input  logic                       mem_rd_ack,
  output logic [WIDTH-1:0]           bus,
  output logic [WIDTH-1:0]           y_q,
  output logic [WIDTH-1:0]           mar_q,
  output logic                       mem_rd_req,
`ifdef BUS_CONTENTION_CHECK_EN
  output logic                       bus_err,
  output logic [4:0]                 err_src,
`endif
  output logic                       busy
);

  localparam int NSRC   = num_src(NUM_GPR);
  localparam int S_HI   = src_idx(NUM_GPR, OFS_HI);
  localparam int S_LO   = src_idx(NUM_GPR, OFS_LO);
  localparam int S_ZHI  = src_idx(NUM_GPR, OFS_ZHI);
  localparam int S_ZLO  = src_idx(NUM_GPR, OFS_ZLO);
  localparam int S_PC   = src_idx(NUM_GPR, OFS_PC);
  localparam int S_MDR  = src_idx(NUM_GPR, OFS_MDR);
  localparam int S_INP  = src_idx(NUM_GPR, OFS_INPORT);
  localparam int S_C    = src_idx(NUM_GPR, OFS_C);

  logic [WIDTH-1:0] r_gpr [NUM_GPR];
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_zhi;
  logic [WIDTH-1:0] r_zlo;
  logic [WIDTH-1:0] r_y;
  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] r_mar;
  logic [WIDTH-1:0] r_mdr;

  rd_state_e r_state;
  rd_state_e w_state_nx;
  logic      w_rd_done;
  logic      w_mdr_bus;

  logic [NSRC*WIDTH-1:0] w_src;
  logic                  w_valid;
  logic [WIDTH-1:0]      w_mux;
  logic [WIDTH-1:0]      w_bus;

  always_comb begin
    w_src = '0;
    for (int g = 0; g < NUM_GPR; g++) begin
      w_src[g*WIDTH +: WIDTH] = r_gpr[g];
    end
    w_src[S_HI*WIDTH  +: WIDTH] = r_hi;
    w_src[S_LO*WIDTH  +: WIDTH] = r_lo;
    w_src[S_ZHI*WIDTH +: WIDTH] = r_zhi;
    w_src[S_ZLO*WIDTH +: WIDTH] = r_zlo;
    w_src[S_PC*WIDTH  +: WIDTH] = r_pc;
    w_src[S_MDR*WIDTH +: WIDTH] = r_mdr;
    w_src[S_INP*WIDTH +: WIDTH] = inport_data;
    w_src[S_C*WIDTH   +: WIDTH] = c_sign_extended;
  end

  bus_encoder_mux #(
    .N     (NSRC),
    .WIDTH (WIDTH)
  ) u_enc (
    .i_sel   (out_en),
    .i_data  (w_src),
    .o_valid (w_valid),
    .o_data  (w_mux)
  );

  assign w_bus = w_valid ? w_mux : '0;
  assign bus   = w_bus;

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      for (int g = 0; g < NUM_GPR; g++) r_gpr[g] <= '0;
    end else begin
      for (int g = 0; g < NUM_GPR; g++) begin
        if (gpr_in[g]) r_gpr[g] <= w_bus;
      end
    end
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      r_hi  <= '0;
      r_lo  <= '0;
      r_zhi <= '0;
      r_zlo <= '0;
      r_y   <= '0;
      r_mar <= '0;
    end else begin
      if (hi_in)  r_hi  <= w_bus;
      if (lo_in)  r_lo  <= w_bus;
      if (y_in)   r_y   <= w_bus;
      if (mar_in) r_mar <= w_bus;
      if (z_in) begin
        r_zhi <= alu_result[2*WIDTH-1:WIDTH];
        r_zlo <= alu_result[WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear)      r_pc <= '0;
    else if (pc_in)  r_pc <= w_bus;
    else if (pc_inc) r_pc <= r_pc + WIDTH'(PC_STEP);
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) r_state <= IDLE;
    else        r_state <= w_state_nx;
  end

  // Bus writes to MDR only happen in IDLE; a read owns MDR until ack.
  always_comb begin
    w_state_nx = r_state;
    w_rd_done  = 1'b0;
    w_mdr_bus  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (mdr_in && mdr_rd)  w_state_nx = READ;
        else if (mdr_in)       w_mdr_bus  = 1'b1;
      end
      READ: begin
        if (mem_rd_ack) begin
          w_rd_done  = 1'b1;
          w_state_nx = IDLE;
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear)         r_mdr <= '0;
    else if (w_rd_done) r_mdr <= mem_rdata;
    else if (w_mdr_bus) r_mdr <= w_bus;
  end

  assign mem_rd_req = (r_state == READ);
  assign busy       = (r_state == READ);
  assign y_q        = r_y;
  assign mar_q      = r_mar;

`ifdef BUS_CONTENTION_CHECK_EN
  localparam logic [NSRC-1:0] ONE = NSRC'(1);

  logic       w_multi;
  logic [4:0] w_top;
  logic       r_bus_err;
  logic [4:0] r_err_src;

  assign w_multi = |(out_en & (out_en - ONE));

  always_comb begin
    w_top = '0;
    for (int k = 0; k < NSRC; k++) begin
      if (out_en[k]) w_top = 5'(k);
    end
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      r_bus_err <= 1'b0;
      r_err_src <= '0;
    end else if (w_multi && !r_bus_err) begin
      r_bus_err <= 1'b1;
      r_err_src <= w_top;
    end
  end

  assign bus_err = r_bus_err;
  assign err_src = r_err_src;
`endif

endmodule
